// File: rtl/vector_datapath_seq.sv
// Vector register file with lane-wise ADD/SUB/MUL and a word-serial LOAD/STORE sequencer.
// Optional macro VPU_SAT_EN: signed saturating ADD/SUB plus a sticky sat_flag output.
module vector_datapath_seq #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 16,
  parameter int unsigned NREGS  = 4,
  parameter int unsigned ADDR_W = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [2:0]                 opcode,
  input  logic [$clog2(NREGS)-1:0]   rd,
  input  logic [$clog2(NREGS)-1:0]   rs1,
  input  logic [$clog2(NREGS)-1:0]   rs2,
  input  logic [ADDR_W-1:0]          base_addr,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_ready,
  input  logic [$clog2(NREGS)-1:0]   dbg_reg,
  input  logic [$clog2(LANES)-1:0]   dbg_lane,
`ifdef VPU_SAT_EN
  output logic                       sat_flag,
`endif
  output logic [DATA_W-1:0]          dbg_data
);

  localparam int unsigned RW = $clog2(NREGS);
  localparam int unsigned LW = $clog2(LANES);
  localparam int unsigned PW = 2 * DATA_W;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_MUL   = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_XFER, S_EXEC, S_WB_HI, S_FIN} state_t;

  state_t              r_state;
  logic [2:0]          r_op;
  logic [RW-1:0]       r_rd;
  logic [RW-1:0]       r_rs1;
  logic [RW-1:0]       r_rs2;
  logic [ADDR_W-1:0]   r_base;
  logic [LW-1:0]       r_k;
  logic [DATA_W-1:0]   r_regs [NREGS][LANES];
  logic [DATA_W-1:0]   r_hi   [LANES];

  logic [PW-1:0]       w_prod [LANES];
  logic [DATA_W-1:0]   w_as   [LANES];
  logic [LW-1:0]       w_next_k;
  logic [ADDR_W-1:0]   w_next_addr;
  logic                w_is_mul;
`ifdef VPU_SAT_EN
  logic [LANES-1:0]    w_lane_sat;
`endif

  // Signed product via sign-extended operands; low PW bits equal the two's-complement result.
  function automatic logic [PW-1:0] f_mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [PW-1:0] ea;
    logic [PW-1:0] eb;
    ea = {{DATA_W{a[DATA_W-1]}}, a};
    eb = {{DATA_W{b[DATA_W-1]}}, b};
    return ea * eb;
  endfunction

`ifdef VPU_SAT_EN
  // Returns {clamped, result}; one guard bit detects signed overflow.
  function automatic logic [DATA_W:0] f_addsub(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic              sub);
    logic [DATA_W:0] s;
    s = sub ? ({a[DATA_W-1], a} - {b[DATA_W-1], b}) : ({a[DATA_W-1], a} + {b[DATA_W-1], b});
    if (s[DATA_W] != s[DATA_W-1])
      return {1'b1, s[DATA_W], {(DATA_W-1){~s[DATA_W]}}};
    return {1'b0, s[DATA_W-1:0]};
  endfunction
`else
  function automatic logic [DATA_W-1:0] f_addsub(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic              sub);
    return sub ? (a - b) : (a + b);
  endfunction
`endif

  assign w_next_k    = LW'(r_k + 1'b1);
  assign w_next_addr = ADDR_W'(r_base + ADDR_W'(w_next_k));
  assign w_is_mul    = (r_op == OP_MUL);
  assign dbg_data    = r_regs[dbg_reg][dbg_lane];

  // Lane-wise arithmetic on the latched sources, consumed in EXEC.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_prod[l] = f_mul(r_regs[r_rs1][l], r_regs[r_rs2][l]);
`ifdef VPU_SAT_EN
      {w_lane_sat[l], w_as[l]} = f_addsub(r_regs[r_rs1][l], r_regs[r_rs2][l], r_op == OP_SUB);
`else
      w_as[l] = f_addsub(r_regs[r_rs1][l], r_regs[r_rs2][l], r_op == OP_SUB);
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_op      <= OP_NOP;
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_base    <= '0;
      r_k       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef VPU_SAT_EN
      sat_flag  <= 1'b0;
`endif
      for (int r = 0; r < NREGS; r++)
        for (int l = 0; l < LANES; l++)
          r_regs[r][l] <= '0;
      for (int l = 0; l < LANES; l++)
        r_hi[l] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op   <= opcode;
            r_rd   <= rd;
            r_rs1  <= rs1;
            r_rs2  <= rs2;
            r_base <= base_addr;
            r_k    <= '0;
            err    <= 1'b0;
`ifdef VPU_SAT_EN
            sat_flag <= 1'b0;
`endif
            case (opcode)
              OP_LOAD, OP_STORE: begin
                r_state   <= S_XFER;
                busy      <= 1'b1;
                mem_req   <= 1'b1;
                mem_we    <= (opcode == OP_STORE);
                mem_addr  <= base_addr;
                mem_wdata <= (opcode == OP_STORE) ? r_regs[rs1][0] : '0;
              end
              OP_ADD, OP_SUB, OP_MUL: begin
                r_state <= S_EXEC;
                busy    <= 1'b1;
              end
              OP_NOP: begin
                r_state <= S_FIN;
                done    <= 1'b1;
              end
              default: begin
                r_state <= S_FIN;
                done    <= 1'b1;
                err     <= 1'b1;
              end
            endcase
          end
        end
        // One lane per completed handshake; request and address hold while mem_ready is low.
        S_XFER: begin
          if (mem_ready) begin
            if (r_op == OP_LOAD)
              r_regs[r_rd][r_k] <= mem_rdata;
            if (r_k == LW'(LANES - 1)) begin
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_k      <= w_next_k;
              mem_addr <= w_next_addr;
              if (r_op == OP_STORE)
                mem_wdata <= r_regs[r_rs1][w_next_k];
            end
          end
        end
        S_EXEC: begin
          for (int l = 0; l < LANES; l++) begin
            r_regs[r_rd][l] <= w_is_mul ? w_prod[l][DATA_W-1:0] : w_as[l];
            r_hi[l]         <= w_prod[l][PW-1:DATA_W];
          end
`ifdef VPU_SAT_EN
          if (!w_is_mul && (|w_lane_sat))
            sat_flag <= 1'b1;
`endif
          if (w_is_mul) begin
            r_state <= S_WB_HI;
          end else begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_FIN;
          end
        end
        // High product halves land in the next register, wrapping past the last one.
        S_WB_HI: begin
          for (int l = 0; l < LANES; l++)
            r_regs[RW'(r_rd + 1'b1)][l] <= r_hi[l];
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_FIN;
        end
        S_FIN: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
